// File: rtl/pc_redirect_ctrl_pkg.sv
// pc_redirect_ctrl_pkg: shared redirect source/state encodings and hold threshold for pc_redirect_ctrl
package pc_redirect_ctrl_pkg;
  typedef enum logic [1:0] {
    REDIR_NONE = 2'd0,
    REDIR_EX   = 2'd1,
    REDIR_INT  = 2'd2,
    REDIR_BP   = 2'd3
  } redir_src_t;
  typedef enum logic [1:0] {
    PC_CTL_IDLE  = 2'd0,
    PC_CTL_PEND  = 2'd1,
    PC_CTL_FLUSH = 2'd2
  } pc_ctl_state_t;
  localparam logic [2:0] HOLD_PC = 3'b001;
  function automatic logic [1:0] src_rank(input redir_src_t s);
    return s == REDIR_EX ? 2'd2 : s == REDIR_INT ? 2'd1 : 2'd0;
  endfunction
endpackage

// File: rtl/redirect_prio_sel.sv
// redirect_prio_sel: combinational two-way selector, input a beats input b
module redirect_prio_sel
  import pc_redirect_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_addr,
  input  redir_src_t        a_src,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_addr,
  input  redir_src_t        b_src,
  output logic              valid,
  output logic [ADDR_W-1:0] addr,
  output redir_src_t        src
);
  assign valid = a_valid || b_valid;
  assign addr  = a_valid ? a_addr : b_valid ? b_addr : '0;
  assign src   = a_valid ? a_src : b_valid ? b_src : REDIR_NONE;
endmodule

// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl: arbitrates EX/INT/BP redirects into pc_reg, pends across ibus stalls, flushes after jumps
module pc_redirect_ctrl
  import pc_redirect_ctrl_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              jtag_reset_flag_i,
  input  logic              ex_jump_flag_i,
  input  logic [ADDR_W-1:0] ex_jump_addr_i,
  input  logic              int_flag_i,
  input  logic [ADDR_W-1:0] int_addr_i,
  output logic              int_ack_o,
  input  logic              bp_valid_i,
  input  logic [ADDR_W-1:0] bp_addr_i,
  input  logic [2:0]        hold_flag_i,
  input  logic              ibus_ready_i,
  output logic              jump_flag_o,
  output logic [ADDR_W-1:0] jump_addr_o,
  output logic              isbranch_o,
  output logic [ADDR_W-1:0] branch_addr_o,
  output logic              flush_o,
  output logic [1:0]        redirect_src_o,
  output logic              pend_o
);
  localparam int CW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(FLUSH_CYCLES);
  pc_ctl_state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [ADDR_W-1:0] pend_addr, pend_addr_nx, live_addr, sel_addr;
  redir_src_t pend_src, pend_src_nx, live_src, sel_src;
  logic en, in_pend, live_v, ovr_v, sel_v, present, capture, bp_take;
  redirect_prio_sel #(.ADDR_W(ADDR_W)) u_live (
    .a_valid(ex_jump_flag_i), .a_addr(ex_jump_addr_i), .a_src(REDIR_EX),
    .b_valid(int_flag_i),     .b_addr(int_addr_i),     .b_src(REDIR_INT),
    .valid(live_v), .addr(live_addr), .src(live_src)
  );
  assign in_pend = state == PC_CTL_PEND;
  assign ovr_v   = live_v && (!in_pend || src_rank(live_src) >= src_rank(pend_src));
  redirect_prio_sel #(.ADDR_W(ADDR_W)) u_merge (
    .a_valid(ovr_v),   .a_addr(live_addr), .a_src(live_src),
    .b_valid(in_pend), .b_addr(pend_addr), .b_src(pend_src),
    .valid(sel_v), .addr(sel_addr), .src(sel_src)
  );
  assign en             = rst && !jtag_reset_flag_i;
  assign present        = en && sel_v && ibus_ready_i;
  assign capture        = en && sel_v && !ibus_ready_i;
  assign bp_take        = en && bp_valid_i && !live_v && state == PC_CTL_IDLE && ibus_ready_i && hold_flag_i < HOLD_PC;
  assign jump_flag_o    = present;
  assign jump_addr_o    = present ? sel_addr : '0;
  assign isbranch_o     = bp_take;
  assign branch_addr_o  = bp_take ? bp_addr_i : '0;
  assign redirect_src_o = present ? sel_src : bp_take ? REDIR_BP : REDIR_NONE;
  assign flush_o        = en && state == PC_CTL_FLUSH;
  assign pend_o         = capture;
  assign int_ack_o      = en && ovr_v && live_src == REDIR_INT;
  // next state: soft reset clears, presenting starts a flush window, stalls pend the winner
  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    pend_addr_nx = pend_addr;
    pend_src_nx  = pend_src;
    if (jtag_reset_flag_i) begin
      state_nx     = PC_CTL_IDLE;
      cnt_nx       = '0;
      pend_addr_nx = '0;
      pend_src_nx  = REDIR_NONE;
    end else if (present) begin
      state_nx     = PC_CTL_FLUSH;
      cnt_nx       = CNT_LOAD;
      pend_addr_nx = '0;
      pend_src_nx  = REDIR_NONE;
    end else if (capture) begin
      state_nx     = PC_CTL_PEND;
      cnt_nx       = '0;
      pend_addr_nx = sel_addr;
      pend_src_nx  = sel_src;
    end else if (state == PC_CTL_FLUSH) begin
      cnt_nx   = cnt - 1'b1;
      state_nx = cnt == CW'(1) ? PC_CTL_IDLE : PC_CTL_FLUSH;
    end
  end
  // state register with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= PC_CTL_IDLE;
      cnt       <= '0;
      pend_addr <= '0;
      pend_src  <= REDIR_NONE;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      pend_addr <= pend_addr_nx;
      pend_src  <= pend_src_nx;
    end
  end
endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// tb_pc_redirect_ctrl: directed and randomized checks of pc_redirect_ctrl against a rule-level model
module tb_pc_redirect_ctrl;
  localparam int FLUSH = 2;
  logic clk = 1'b0, rst = 1'b0, jtag_reset_flag_i = 1'b0;
  logic ex_jump_flag_i = 1'b0, int_flag_i = 1'b0, bp_valid_i = 1'b0, ibus_ready_i = 1'b1;
  logic [31:0] ex_jump_addr_i = '0, int_addr_i = '0, bp_addr_i = '0;
  logic [2:0] hold_flag_i = '0;
  logic int_ack_o, jump_flag_o, isbranch_o, flush_o, pend_o;
  logic [31:0] jump_addr_o, branch_addr_o;
  logic [1:0] redirect_src_o;
  int n_chk = 0, n_fail = 0;
  logic m_pv = 1'b0;
  logic [31:0] m_pa = '0;
  logic [1:0] m_ps = '0;
  int m_fl = 0;
  typedef struct packed {
    logic jump, pend, ack, br, flush;
    logic [1:0] src, cs;
    logic [31:0] ja, ba, ca;
  } exp_t;
  pc_redirect_ctrl #(.ADDR_W(32), .FLUSH_CYCLES(FLUSH)) dut (
    .clk(clk), .rst(rst), .jtag_reset_flag_i(jtag_reset_flag_i),
    .ex_jump_flag_i(ex_jump_flag_i), .ex_jump_addr_i(ex_jump_addr_i),
    .int_flag_i(int_flag_i), .int_addr_i(int_addr_i), .int_ack_o(int_ack_o),
    .bp_valid_i(bp_valid_i), .bp_addr_i(bp_addr_i), .hold_flag_i(hold_flag_i),
    .ibus_ready_i(ibus_ready_i), .jump_flag_o(jump_flag_o), .jump_addr_o(jump_addr_o),
    .isbranch_o(isbranch_o), .branch_addr_o(branch_addr_o), .flush_o(flush_o),
    .redirect_src_o(redirect_src_o), .pend_o(pend_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic int rank(input logic [1:0] s);
    return s == 2'd1 ? 2 : s == 2'd2 ? 1 : 0;
  endfunction
  function automatic exp_t model_now();
    exp_t e;
    logic en, lv, cl, cv;
    logic [1:0] ls;
    logic [31:0] la;
    e = '0;
    en = rst && !jtag_reset_flag_i;
    lv = ex_jump_flag_i || int_flag_i;
    ls = ex_jump_flag_i ? 2'd1 : int_flag_i ? 2'd2 : 2'd0;
    la = ex_jump_flag_i ? ex_jump_addr_i : int_flag_i ? int_addr_i : 32'd0;
    if (m_pv && !(lv && rank(ls) >= rank(m_ps))) begin
      e.cs = m_ps; e.ca = m_pa; cl = 1'b0;
    end else begin
      e.cs = ls; e.ca = la; cl = lv;
    end
    cv = m_pv || lv;
    e.jump  = en && cv && ibus_ready_i;
    e.pend  = en && cv && !ibus_ready_i;
    e.ack   = en && cl && e.cs == 2'd2;
    e.br    = en && bp_valid_i && !lv && !m_pv && m_fl == 0 && ibus_ready_i && hold_flag_i == 3'd0;
    e.flush = en && m_fl > 0 && !m_pv;
    e.src   = e.jump ? e.cs : e.br ? 2'd3 : 2'd0;
    e.ja    = e.jump ? e.ca : 32'd0;
    e.ba    = e.br ? bp_addr_i : 32'd0;
    return e;
  endfunction
  always @(posedge clk or negedge rst) begin
    exp_t e;
    e = model_now();
    if (!rst || jtag_reset_flag_i) begin
      m_pv <= 1'b0; m_pa <= '0; m_ps <= '0; m_fl <= 0;
    end else if (e.jump) begin
      m_pv <= 1'b0; m_fl <= FLUSH;
    end else if (e.pend) begin
      m_pv <= 1'b1; m_pa <= e.ca; m_ps <= e.cs; m_fl <= 0;
    end else if (m_fl > 0) begin
      m_fl <= m_fl - 1;
    end
  end
  always @(negedge clk) begin
    exp_t e;
    e = model_now();
    chk("jump_flag", 32'(jump_flag_o), 32'(e.jump));
    chk("jump_addr", jump_addr_o, e.ja);
    chk("isbranch", 32'(isbranch_o), 32'(e.br));
    chk("branch_addr", branch_addr_o, e.ba);
    chk("flush", 32'(flush_o), 32'(e.flush));
    chk("pend", 32'(pend_o), 32'(e.pend));
    chk("int_ack", 32'(int_ack_o), 32'(e.ack));
    chk("redirect_src", 32'(redirect_src_o), 32'(e.src));
  end
  task automatic drive(input logic ex, input logic [31:0] exa, input logic inf, input logic [31:0] ina,
                       input logic bp, input logic [31:0] bpa, input logic [2:0] hold, input logic rdy,
                       input logic jt);
    @(posedge clk);
    #1;
    ex_jump_flag_i = ex; ex_jump_addr_i = exa; int_flag_i = inf; int_addr_i = ina;
    bp_valid_i = bp; bp_addr_i = bpa; hold_flag_i = hold; ibus_ready_i = rdy; jtag_reset_flag_i = jt;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
  endtask
  task automatic outs_zero(input string name);
    chk(name, {jump_flag_o, isbranch_o, flush_o, pend_o, int_ack_o, redirect_src_o, 25'd0}, 32'd0);
    chk(name, jump_addr_o | branch_addr_o, 32'd0);
  endtask
  initial begin
    exp_t e;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      idle(1);
      #3 outs_zero("idle_after_reset");
    end
    drive(1, 32'h100, 0, 0, 0, 0, 0, 1, 0);
    #3 chk("ex_jump", 32'(jump_flag_o), 32'd1);
    chk("ex_addr", jump_addr_o, 32'h100);
    chk("ex_src", 32'(redirect_src_o), 32'd1);
    e = model_now();
    chk("model_ex_addr", e.ja, 32'h100);
    idle(1);
    #3 chk("ex_flush1", 32'(flush_o), 32'd1);
    idle(1);
    #3 chk("ex_flush2", 32'(flush_o), 32'd1);
    idle(1);
    #3 chk("ex_flush_end", 32'(flush_o), 32'd0);
    drive(0, 0, 1, 32'h80, 0, 0, 0, 0, 0);
    #3 chk("t0_ack", 32'(int_ack_o), 32'd1);
    chk("t0_pend", 32'(pend_o), 32'd1);
    drive(1, 32'h200, 0, 0, 0, 0, 0, 0, 0);
    #3 chk("t1_pend", 32'(pend_o), 32'd1);
    chk("t1_noack", 32'(int_ack_o), 32'd0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #3 chk("t2_pend", 32'(pend_o), 32'd1);
    chk("t2_nojump", 32'(jump_flag_o), 32'd0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    #3 chk("t3_jump", 32'(jump_flag_o), 32'd1);
    chk("t3_addr", jump_addr_o, 32'h200);
    chk("t3_src", 32'(redirect_src_o), 32'd1);
    chk("t3_pend", 32'(pend_o), 32'd0);
    idle(3);
    drive(1, 32'h40, 1, 32'h80, 1, 32'h90, 0, 1, 0);
    #3 chk("tri_addr", jump_addr_o, 32'h40);
    chk("tri_ack", 32'(int_ack_o), 32'd0);
    chk("tri_br", 32'(isbranch_o), 32'd0);
    drive(0, 0, 1, 32'h80, 0, 0, 0, 1, 0);
    #3 chk("int_addr", jump_addr_o, 32'h80);
    chk("int_src", 32'(redirect_src_o), 32'd2);
    chk("int_ack", 32'(int_ack_o), 32'd1);
    e = model_now();
    chk("model_int_addr", e.ja, 32'h80);
    idle(3);
    drive(0, 0, 0, 0, 1, 32'h300, 3'b001, 1, 0);
    #3 chk("bp_hold", 32'(isbranch_o), 32'd0);
    drive(0, 0, 0, 0, 1, 32'h300, 3'b000, 1, 0);
    #3 chk("bp_take", 32'(isbranch_o), 32'd1);
    chk("bp_addr", branch_addr_o, 32'h300);
    chk("bp_src", 32'(redirect_src_o), 32'd3);
    e = model_now();
    chk("model_bp_addr", e.ba, 32'h300);
    idle(1);
    #3 chk("bp_noflush", 32'(flush_o), 32'd0);
    drive(1, 32'h500, 0, 0, 0, 0, 0, 0, 0);
    #3 chk("rst_pend", 32'(pend_o), 32'd1);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    #1 rst = 1'b0;
    #1 outs_zero("async_rst");
    @(posedge clk);
    #1 rst = 1'b1;
    idle(1);
    #3 outs_zero("no_stale");
    drive(1, 32'h600, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 32'h700, 1, 32'h80, 1, 32'h44, 0, 1, 1);
    #3 outs_zero("jtag_force");
    idle(1);
    #3 outs_zero("jtag_cleared");
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 7) == 0, $urandom, $urandom_range(0, 5) == 0, $urandom,
            $urandom_range(0, 2) == 0, $urandom,
            $urandom_range(0, 2) == 0 ? 3'($urandom_range(1, 7)) : 3'd0,
            $urandom_range(0, 9) < 7, $urandom_range(0, 63) == 0);
    end
    idle(4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
